// File: rtl/shift_reg_feeder.sv
// shift_reg_feeder: buffers {shift, data} words from a valid/ready upstream in a
// small FIFO and issues one word per issue slot onto the ShiftRegister inputs.
// A programmable idle gap follows each issue; a downstream hold blocks issue.
//
// Ports:
//   clk          clock, all logic on posedge
//   reset        synchronous, active-high
//   in_valid     upstream word valid
//   in_ready     FIFO can accept (count < DEPTH and not in reset)
//   in_data      upstream word
//   in_shift     per-word mode bit, stored with in_data
//   hold         downstream stall, blocks issue only
//   dataIn       registered word to ShiftRegister (holds when not issuing)
//   enable       registered, high one cycle per issued word
//   shiftEnable  registered, mode bit of issued word, 0 when enable=0
//   level        registered FIFO occupancy (only with FEEDER_LEVEL_EN defined)
//
// Build option: define FEEDER_LEVEL_EN to add the level output.

module shift_reg_feeder #(
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_shift,
  input  logic              hold,
  output logic [DATA_W-1:0] dataIn,
  output logic              enable,
`ifdef FEEDER_LEVEL_EN
  output logic              shiftEnable,
  output logic [ADDR_W:0]   level
`else
  output logic              shiftEnable
`endif
);

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  typedef struct packed {
    logic              shift;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  entry_t            mem [DEPTH];
  entry_t            rd_entry;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              sh_q, sh_d;

  logic              wr_en;
  logic              rd_en;

  // Flow control and issue qualification from registered state only
  assign in_ready = (count_q < CNT_W'(DEPTH)) && !reset;
  assign wr_en    = in_valid && in_ready;
  assign rd_en    = (state_q == ST_IDLE) && (count_q != '0) && !hold;
  assign rd_entry = mem[rd_ptr_q];

  // Next-state logic: pointers, occupancy, issue outputs and gap FSM
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    en_d     = 1'b0;
    sh_d     = 1'b0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      data_d   = rd_entry.data;
      sh_d     = rd_entry.shift;
      en_d     = 1'b1;
    end

    // Simultaneous write and issue leave the count unchanged
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (rd_en && (GAP_CYCLES > 0)) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_LOAD);
        end
      end
      ST_GAP: begin
        // Countdown ignores hold so a stall never lengthens the gap
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      sh_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      en_q     <= en_d;
      sh_q     <= sh_d;
    end
  end

  // Storage array; contents are don't-care while count is 0
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= entry_t'({in_shift, in_data});
    end
  end

  assign dataIn      = data_q;
  assign enable      = en_q;
  assign shiftEnable = sh_q;

`ifdef FEEDER_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: tb/tb_shift_reg_feeder.sv
// Bench for shift_reg_feeder: directed vector table plus hand-written
// sequences for fill/drain, gap timing, full-with-issue, mid-run reset, and a
// random run against a queue model. Instance a uses GAP_CYCLES=0, b uses 2.

module tb_shift_reg_feeder;

  localparam int unsigned DW = 6;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_valid, a_ready, a_shift, a_hold, a_en, a_sh;
  logic [DW-1:0] a_din, a_dout;
  logic          b_reset, b_valid, b_ready, b_shift, b_hold, b_en, b_sh;
  logic [DW-1:0] b_din, b_dout;
`ifdef FEEDER_LEVEL_EN
  logic [3:0]    a_level, b_level;
`endif

  shift_reg_feeder #(.DATA_W(6), .DEPTH(8), .ADDR_W(3), .GAP_CYCLES(0)) u_a (
    .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_din), .in_shift(a_shift), .hold(a_hold),
    .dataIn(a_dout), .enable(a_en),
`ifdef FEEDER_LEVEL_EN
    .shiftEnable(a_sh), .level(a_level)
`else
    .shiftEnable(a_sh)
`endif
  );

  shift_reg_feeder #(.DATA_W(6), .DEPTH(8), .ADDR_W(3), .GAP_CYCLES(2)) u_b (
    .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_din), .in_shift(b_shift), .hold(b_hold),
    .dataIn(b_dout), .enable(b_en),
`ifdef FEEDER_LEVEL_EN
    .shiftEnable(b_sh), .level(b_level)
`else
    .shiftEnable(b_sh)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic          valid;
    logic [DW-1:0] din;
    logic          shift;
    logic          hold;
    logic          en;
    logic          sh;
    logic [DW-1:0] dout;
    logic          rdy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic valid, input logic [DW-1:0] din,
                              input logic shift, input logic hold, input logic en,
                              input logic sh, input logic [DW-1:0] dout, input logic rdy);
    vec_t v;
    v.rst = rst; v.valid = valid; v.din = din; v.shift = shift; v.hold = hold;
    v.en = en; v.sh = sh; v.dout = dout; v.rdy = rdy;
    return v;
  endfunction

  vec_t vecs [9];
  int   en3  [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
  int   d3   [9] = '{0, 1, 1, 1, 2, 2, 2, 3, 3};
  int   sh3  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

  logic [DW:0] q [$];
  logic [DW:0] last_w;
  logic        exp_rdy, exp_en;

  initial begin
    a_reset = H; a_valid = L; a_din = '0; a_shift = L; a_hold = L;
    b_reset = H; b_valid = L; b_din = '0; b_shift = L; b_hold = L;

    // Expected values are those seen just after the edge that applied the inputs
    vecs[0] = mk(H, L, 6'd0,  L, L, L, L, 6'd0,  L);
    vecs[1] = mk(L, H, 6'd49, H, L, L, L, 6'd0,  H);
    vecs[2] = mk(L, L, 6'd0,  L, L, H, H, 6'd49, H);
    vecs[3] = mk(L, L, 6'd0,  L, L, L, L, 6'd49, H);
    vecs[4] = mk(L, H, 6'd10, L, L, L, L, 6'd49, H);
    vecs[5] = mk(L, H, 6'd11, H, L, H, L, 6'd10, H);
    vecs[6] = mk(L, L, 6'd0,  L, H, L, L, 6'd10, H);
    vecs[7] = mk(L, L, 6'd0,  L, L, H, H, 6'd11, H);
    vecs[8] = mk(L, L, 6'd0,  L, L, L, L, 6'd11, H);

    // Single-word latency, hold gating and dataIn retention
    for (int i = 0; i < 9; i++) begin
      a_reset = vecs[i].rst; a_valid = vecs[i].valid; a_din = vecs[i].din;
      a_shift = vecs[i].shift; a_hold = vecs[i].hold;
      tick();
      check($sformatf("vec%0d_enable", i), 32'(a_en), 32'(vecs[i].en));
      check($sformatf("vec%0d_shiftEnable", i), 32'(a_sh), 32'(vecs[i].sh));
      check($sformatf("vec%0d_dataIn", i), 32'(a_dout), 32'(vecs[i].dout));
      check($sformatf("vec%0d_in_ready", i), 32'(a_ready), 32'(vecs[i].rdy));
    end
    check("b_reset_enable", 32'(b_en), 32'(0));
    check("b_reset_dataIn", 32'(b_dout), 32'(0));

    // Fill to full under hold (pointers wrap), then drain back-to-back in order
    a_hold = H; a_valid = H;
    for (int i = 0; i < 8; i++) begin
      a_din = DW'(i); a_shift = 1'(i);
      #1;
      check($sformatf("fill%0d_in_ready", i), 32'(a_ready), 32'(1));
      tick();
      check($sformatf("fill%0d_enable", i), 32'(a_en), 32'(0));
    end
    check("full_in_ready", 32'(a_ready), 32'(0));
`ifdef FEEDER_LEVEL_EN
    check("full_level", 32'(a_level), 32'(8));
`endif
    a_valid = L; a_hold = L;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("drain%0d_enable", i), 32'(a_en), 32'(1));
      check($sformatf("drain%0d_dataIn", i), 32'(a_dout), 32'(i));
      check($sformatf("drain%0d_shiftEnable", i), 32'(a_sh), 32'(i % 2));
    end
    tick();
    check("drain_done_enable", 32'(a_en), 32'(0));
    check("drain_done_in_ready", 32'(a_ready), 32'(1));

    // Full FIFO with issue in the same cycle: the upstream word waits one edge
    a_hold = H; a_valid = H; a_shift = L;
    for (int i = 0; i < 8; i++) begin
      a_din = DW'(20 + i);
      tick();
    end
    a_din = 6'd40; a_shift = H; a_hold = L;
    #1;
    check("fullissue_ready_before", 32'(a_ready), 32'(0));
    tick();
    check("fullissue_enable", 32'(a_en), 32'(1));
    check("fullissue_dataIn", 32'(a_dout), 32'(20));
    check("fullissue_ready_after", 32'(a_ready), 32'(1));
`ifdef FEEDER_LEVEL_EN
    check("fullissue_level7", 32'(a_level), 32'(7));
`endif
    a_hold = H;
    tick();
    check("refill_enable", 32'(a_en), 32'(0));
    check("refill_in_ready", 32'(a_ready), 32'(0));
`ifdef FEEDER_LEVEL_EN
    check("refill_level8", 32'(a_level), 32'(8));
`endif
    a_valid = L; a_hold = L;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("fdrain%0d_enable", i), 32'(a_en), 32'(1));
      check($sformatf("fdrain%0d_dataIn", i), 32'(a_dout), (i < 7) ? 32'(21 + i) : 32'(40));
      check($sformatf("fdrain%0d_shiftEnable", i), 32'(a_sh), (i == 7) ? 32'(1) : 32'(0));
    end
    tick();
    check("fdrain_done_enable", 32'(a_en), 32'(0));

    // Reset with five words buffered discards them
    a_hold = H; a_valid = H; a_shift = H;
    for (int i = 0; i < 5; i++) begin
      a_din = DW'(50 + i);
      tick();
    end
    a_valid = L; a_hold = L; a_reset = H;
    tick();
    check("rst_enable", 32'(a_en), 32'(0));
    check("rst_dataIn", 32'(a_dout), 32'(0));
    check("rst_shiftEnable", 32'(a_sh), 32'(0));
    check("rst_in_ready", 32'(a_ready), 32'(0));
    a_reset = L;
    #1;
    check("postrst_in_ready", 32'(a_ready), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postrst%0d_enable", i), 32'(a_en), 32'(0));
      check($sformatf("postrst%0d_dataIn", i), 32'(a_dout), 32'(0));
    end

    // GAP_CYCLES=2: enable 1,0,0,1,0,0,1 and a hold inside a gap does not stretch it
    b_reset = L;
    for (int e = 0; e < 9; e++) begin
      b_valid = (e < 3); b_din = DW'(e + 1); b_shift = (e == 1); b_hold = (e == 5);
      tick();
      check($sformatf("gap%0d_enable", e), 32'(b_en), 32'(en3[e]));
      check($sformatf("gap%0d_dataIn", e), 32'(b_dout), 32'(d3[e]));
      check($sformatf("gap%0d_shiftEnable", e), 32'(b_sh), 32'(sh3[e]));
    end

    // Random traffic against a queue model
    last_w = '0;
    for (int c = 0; c < 5000; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_din   = DW'($urandom);
      a_shift = 1'($urandom);
      a_hold  = ($urandom_range(0, 9) < 3);
      #1;
      exp_rdy = (q.size() < 8);
      check("rand_in_ready", 32'(a_ready), 32'(exp_rdy));
      exp_en = (q.size() != 0) && !a_hold;
      if (exp_en) last_w = q.pop_front();
      if (a_valid && exp_rdy) q.push_back({a_shift, a_din});
      tick();
      check("rand_enable", 32'(a_en), 32'(exp_en));
      check("rand_dataIn", 32'(a_dout), 32'(last_w[DW-1:0]));
      check("rand_shiftEnable", 32'(a_sh), exp_en ? 32'(last_w[DW]) : 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
